// File: rtl/tama_pkg.sv
// Shared definitions for the command parser.
// Holds the FSM state encoding, the command-code and error-code constants,
// the ASCII byte values of the frame grammar and small byte-classifier
// helpers used by the parser's next-state logic.
package tama_pkg;

  // Parser FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GOT_START = 2'd1,
    ST_GOT_CMD   = 2'd2,
    ST_GOT_ARG   = 2'd3
  } state_t;

  // Command identifiers reported on cmd_code.
  localparam logic [2:0] CMD_FEED  = 3'd0;
  localparam logic [2:0] CMD_PLAY  = 3'd1;
  localparam logic [2:0] CMD_CLEAN = 3'd2;
  localparam logic [2:0] CMD_SLEEP = 3'd3;
  localparam logic [2:0] CMD_WAKE  = 3'd4;
  localparam logic [2:0] CMD_TALK  = 3'd5;

  // Error identifiers reported on err_code.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_BAD_ARG = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // ASCII values used by the frame grammar.
  localparam logic [7:0] ASC_BANG = 8'h21;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_F    = 8'h46;
  localparam logic [7:0] ASC_P    = 8'h50;
  localparam logic [7:0] ASC_C    = 8'h43;
  localparam logic [7:0] ASC_S    = 8'h53;
  localparam logic [7:0] ASC_W    = 8'h57;
  localparam logic [7:0] ASC_T    = 8'h54;

  // True for one of the six legal uppercase command letters.
  function automatic logic is_cmd_letter(input logic [7:0] b);
    logic v;
    case (b)
      ASC_F, ASC_P, ASC_C, ASC_S, ASC_W, ASC_T: v = 1'b1;
      default:                                  v = 1'b0;
    endcase
    return v;
  endfunction

  // Maps a legal command letter to its code; non-letters map to FEED but
  // callers only use the result after is_cmd_letter() said yes.
  function automatic logic [2:0] cmd_code_of(input logic [7:0] b);
    logic [2:0] c;
    case (b)
      ASC_F:   c = CMD_FEED;
      ASC_P:   c = CMD_PLAY;
      ASC_C:   c = CMD_CLEAN;
      ASC_S:   c = CMD_SLEEP;
      ASC_W:   c = CMD_WAKE;
      ASC_T:   c = CMD_TALK;
      default: c = CMD_FEED;
    endcase
    return c;
  endfunction

  // True for ASCII '0'..'9'.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  // True for a frame terminator (CR or LF).
  function automatic logic is_term(input logic [7:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/cmd_parser_byte_strobe.sv
// byte_strobe: turns the level-style UART byte bus into a one-cycle strobe.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_data      - received byte, 8'h00 means "no byte"
//   o_strobe    - high for exactly one cycle when a new nonzero byte appears
//   o_byte      - the byte accompanying o_strobe
module byte_strobe
  import tama_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  output logic       o_strobe,
  output logic [7:0] o_byte
);

  logic [7:0] r_prev;
  // r_armed stays low after reset until the bus has been seen idle, so a byte
  // that was already being held across reset release cannot fire a strobe.
  logic       r_armed;
  logic       w_strobe;

  // Previous-value register and post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 8'h00;
      r_armed <= 1'b0;
    end else begin
      r_prev <= i_data;
      if (i_data == 8'h00) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Rising edge from zero to nonzero, gated by the arming flag.
  assign w_strobe = (i_data != 8'h00) && (r_prev == 8'h00) && r_armed;

  assign o_strobe = w_strobe;
  assign o_byte   = i_data;

endmodule

// File: rtl/cmd_parser.sv
// cmd_parser: decodes "!<letter>[digit]<CR|LF>" command frames from a UART
// byte stream into one-cycle command or error pulses.
// Ports:
//   clk, rst_n  - 27 MHz clock, asynchronous active-low reset
//   rx_data     - received byte (8'h00 = no byte)
//   cmd_valid   - one-cycle pulse, legal frame accepted
//   cmd_code    - command id (held between pulses)
//   cmd_arg     - repeat count 0..9 (held between pulses)
//   err         - one-cycle pulse, frame rejected
//   err_code    - 1 bad letter, 2 bad arg/terminator, 3 timeout (held)
//   busy        - a frame is in progress
module cmd_parser
  import tama_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 27_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] cmd_arg,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  // The timeout fires on the edge where the counter would reach
  // TIMEOUT_CYCLES-1, so the err pulse appears TIMEOUT_CYCLES cycles after
  // the last strobe.
  localparam logic [24:0] TO_LAST = 25'(TIMEOUT_CYCLES - 2);

  logic       w_strobe;
  logic [7:0] w_byte;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [24:0] r_cnt;
  logic [2:0] r_code_lat;
  logic [2:0] w_code_lat_nxt;
  logic [3:0] r_arg_lat;
  logic [3:0] w_arg_lat_nxt;
  logic       w_emit;
  logic [3:0] w_emit_arg;
  logic       w_fail;
  logic [1:0] w_fail_code;

  byte_strobe u_byte_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   (rx_data),
    .o_strobe (w_strobe),
    .o_byte   (w_byte)
  );

  // FSM state register and in-frame latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_code_lat <= CMD_FEED;
      r_arg_lat  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_code_lat <= w_code_lat_nxt;
      r_arg_lat  <= w_arg_lat_nxt;
    end
  end

  // Next-state logic: byte handling first, timeout only when no byte arrived.
  always_comb begin
    w_state_nxt    = r_state;
    w_code_lat_nxt = r_code_lat;
    w_arg_lat_nxt  = r_arg_lat;
    w_emit         = 1'b0;
    w_emit_arg     = r_arg_lat;
    w_fail         = 1'b0;
    w_fail_code    = ERR_NONE;
    if (w_strobe) begin
      if (w_byte == ASC_BANG) begin
        // '!' always (re)starts a frame; an abandoned frame is dropped quietly.
        w_state_nxt = ST_GOT_START;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt = ST_IDLE;
          end
          ST_GOT_START: begin
            if (is_cmd_letter(w_byte)) begin
              w_state_nxt    = ST_GOT_CMD;
              w_code_lat_nxt = cmd_code_of(w_byte);
            end else begin
              w_state_nxt = ST_IDLE;
              w_fail      = 1'b1;
              w_fail_code = ERR_BAD_CMD;
            end
          end
          ST_GOT_CMD: begin
            if (is_digit(w_byte)) begin
              w_state_nxt   = ST_GOT_ARG;
              // '0'..'9' are 8'h30..8'h39, so the low nibble is the value.
              w_arg_lat_nxt = w_byte[3:0];
            end else if (is_term(w_byte)) begin
              w_state_nxt = ST_IDLE;
              w_emit      = 1'b1;
              w_emit_arg  = 4'd1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_fail      = 1'b1;
              w_fail_code = ERR_BAD_ARG;
            end
          end
          ST_GOT_ARG: begin
            if (is_term(w_byte)) begin
              w_state_nxt = ST_IDLE;
              w_emit      = 1'b1;
              w_emit_arg  = r_arg_lat;
            end else begin
              w_state_nxt = ST_IDLE;
              w_fail      = 1'b1;
              w_fail_code = ERR_BAD_ARG;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end else if ((r_state != ST_IDLE) && (r_cnt == TO_LAST)) begin
      w_state_nxt = ST_IDLE;
      w_fail      = 1'b1;
      w_fail_code = ERR_TIMEOUT;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Inter-byte timeout counter: zero in IDLE and on every strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 25'd0;
    end else if (w_strobe || (w_state_nxt == ST_IDLE)) begin
      r_cnt <= 25'd0;
    end else begin
      r_cnt <= r_cnt + 25'd1;
    end
  end

  // Registered outputs; codes only change when their pulse fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      cmd_arg   <= 4'd0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= w_emit;
      err       <= w_fail;
      busy      <= (w_state_nxt != ST_IDLE);
      if (w_emit) begin
        cmd_code <= r_code_lat;
        cmd_arg  <= w_emit_arg;
      end else begin
        cmd_code <= cmd_code;
        cmd_arg  <= cmd_arg;
      end
      if (w_fail) begin
        err_code <= w_fail_code;
      end else begin
        err_code <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser (TIMEOUT_CYCLES = 100).
module tb_cmd_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] cmd_arg;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int last_valid_cyc = -1;
  int last_err_cyc = -1;
  int last_strobe_cyc = 0;

  cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_arg   (cmd_arg),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_valid) begin
      n_valid <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (err) begin
      n_err <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (cmd_valid && err) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive byte b for 'hold' cycles followed by 'gap' (>=1) zero cycles.
  task automatic put(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    last_strobe_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    rx_data = 8'h00;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  int v0, e0, t, s;

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_code", {29'd0, cmd_code}, 32'd0);
    chk("rst_arg", {28'd0, cmd_arg}, 32'd0);
    chk("rst_errcode", {30'd0, err_code}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // "!F3\r", 50-cycle holds with 5 zero cycles between bytes.
    v0 = n_valid; e0 = n_err;
    put(8'h21, 50, 5);
    @(negedge clk);
    chk("f3_busy_mid", {31'd0, busy}, 32'd1);
    put(8'h46, 50, 5);
    put(8'h33, 50, 5);
    put(8'h0D, 50, 5);
    t = last_strobe_cyc;
    @(negedge clk);
    chk("f3_nvalid", n_valid - v0, 32'd1);
    chk("f3_code", {29'd0, cmd_code}, 32'd0);
    chk("f3_arg", {28'd0, cmd_arg}, 32'd3);
    chk("f3_latency", last_valid_cyc, t + 1);
    chk("f3_noerr", n_err - e0, 32'd0);
    chk("f3_busy_after", {31'd0, busy}, 32'd0);

    // "!T\n" -> default argument 1.
    v0 = n_valid;
    put(8'h21, 3, 2); put(8'h54, 3, 2); put(8'h0A, 3, 2);
    @(negedge clk);
    chk("t_nvalid", n_valid - v0, 32'd1);
    chk("t_code", {29'd0, cmd_code}, 32'd5);
    chk("t_arg", {28'd0, cmd_arg}, 32'd1);

    // "!X\r" -> bad letter, CR then ignored.
    v0 = n_valid; e0 = n_err;
    put(8'h21, 3, 2); put(8'h58, 3, 2);
    t = last_strobe_cyc;
    put(8'h0D, 3, 2);
    @(negedge clk);
    chk("x_nerr", n_err - e0, 32'd1);
    chk("x_errcode", {30'd0, err_code}, 32'd1);
    chk("x_latency", last_err_cyc, t + 1);
    chk("x_nvalid", n_valid - v0, 32'd0);
    chk("x_busy", {31'd0, busy}, 32'd0);
    chk("x_code_hold", {29'd0, cmd_code}, 32'd5);

    // "!P7x" -> bad terminator.
    e0 = n_err;
    put(8'h21, 3, 2); put(8'h50, 3, 2); put(8'h37, 3, 2); put(8'h78, 3, 2);
    @(negedge clk);
    chk("p7x_nerr", n_err - e0, 32'd1);
    chk("p7x_errcode", {30'd0, err_code}, 32'd2);

    // "!!C\r" -> second '!' restarts silently.
    v0 = n_valid; e0 = n_err;
    put(8'h21, 3, 2); put(8'h21, 3, 2); put(8'h43, 3, 2); put(8'h0D, 3, 2);
    @(negedge clk);
    chk("bbc_nvalid", n_valid - v0, 32'd1);
    chk("bbc_code", {29'd0, cmd_code}, 32'd2);
    chk("bbc_arg", {28'd0, cmd_arg}, 32'd1);
    chk("bbc_noerr", n_err - e0, 32'd0);

    // "!S" then silence -> timeout 100 cycles after the 'S' strobe.
    e0 = n_err;
    put(8'h21, 3, 2); put(8'h53, 5, 1);
    s = last_strobe_cyc;
    wait_until(s + 98);
    @(negedge clk);
    chk("to_not_early", n_err - e0, 32'd0);
    wait_until(s + 103);
    @(negedge clk);
    chk("to_nerr", n_err - e0, 32'd1);
    chk("to_errcode", {30'd0, err_code}, 32'd3);
    chk("to_cycle", last_err_cyc, s + 100);
    chk("to_busy", {31'd0, busy}, 32'd0);

    // Byte arriving exactly on the timeout cycle wins.
    v0 = n_valid; e0 = n_err;
    put(8'h21, 3, 2); put(8'h53, 5, 1);
    s = last_strobe_cyc;
    wait_until(s + 99);
    rx_data = 8'h37;
    repeat (3) @(posedge clk);
    #1; rx_data = 8'h00;
    wait_until(s + 108);
    @(negedge clk);
    chk("race_noerr", n_err - e0, 32'd0);
    chk("race_busy", {31'd0, busy}, 32'd1);
    put(8'h0D, 3, 2);
    @(negedge clk);
    chk("race_nvalid", n_valid - v0, 32'd1);
    chk("race_code", {29'd0, cmd_code}, 32'd3);
    chk("race_arg", {28'd0, cmd_arg}, 32'd7);
    chk("race_noerr2", n_err - e0, 32'd0);

    // Reset mid-frame with 'W' held on the bus.
    v0 = n_valid; e0 = n_err;
    put(8'h21, 3, 2);
    @(posedge clk); #1; rx_data = 8'h57;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rw_busy_pre", {31'd0, busy}, 32'd1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("rw_busy_rst", {31'd0, busy}, 32'd0);
    chk("rw_code_rst", {29'd0, cmd_code}, 32'd0);
    chk("rw_errcode_rst", {30'd0, err_code}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rw_busy_post", {31'd0, busy}, 32'd0);
    chk("rw_nvalid", n_valid - v0, 32'd0);
    chk("rw_nerr", n_err - e0, 32'd0);

    // Reset release with '!' held: must not start a frame until bus idles.
    @(posedge clk); #1; rst_n = 1'b0; rx_data = 8'h21;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rb_held_nostrobe", {31'd0, busy}, 32'd0);
    @(posedge clk); #1; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    v0 = n_valid;
    put(8'h21, 3, 2);
    @(negedge clk);
    chk("rb_rearmed", {31'd0, busy}, 32'd1);
    put(8'h57, 3, 2); put(8'h0D, 3, 2);
    @(negedge clk);
    chk("rb_nvalid", n_valid - v0, 32'd1);
    chk("rb_code", {29'd0, cmd_code}, 32'd4);
    chk("rb_arg", {28'd0, cmd_arg}, 32'd1);

    chk("never_both", n_both, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 27_000_000, maximum clock cycles allowed between bytes of one frame (1 s at 27 MHz).
REQ-002 clk  input  1  system clock, 27 MHz, rising-edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 rx_data  input  8  received byte from the UART receive stage; 8'h00 = no byte; nonzero = byte held valid for one or more cycles.
REQ-005 cmd_valid  output  1  one-cycle pulse: a complete, legal command frame was accepted.
REQ-006 cmd_code  output  3  command id, valid while cmd_valid is high: 0 feed 'F', 1 play 'P', 2 clean 'C', 3 sleep 'S', 4 wake 'W', 5 talk 'T'.
REQ-007 cmd_arg  output  4  repeat count 0..9, valid while cmd_valid is high.
REQ-008 err  output  1  one-cycle pulse: a frame was rejected.
REQ-009 err_code  output  2  valid while err is high: 1 bad command letter, 2 bad argument or terminator, 3 inter-byte timeout.
REQ-010 busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-011 Byte strobe: the block SHALL register rx_data and SHALL detect exactly one new byte on each cycle where rx_data != 0 and the registered previous value == 0; held nonzero values SHALL NOT re-trigger.
REQ-012 Frame grammar: '!' (8'h21), command letter, optional digit '0'-'9', terminator '\r' (8'h0D) or '\n' (8'h0A).
REQ-013 FSM states: IDLE, GOT_START, GOT_CMD, GOT_ARG.
REQ-014 IDLE: '!' -> GOT_START; any other byte is ignored silently, with no err pulse.
REQ-015 GOT_START: legal uppercase letter -> GOT_CMD and latch code; any other byte -> err_code 1, return to IDLE.
REQ-016 GOT_CMD: digit -> GOT_ARG and latch arg = byte - 8'h30; terminator -> emit with arg = 1; other byte -> err_code 2, return to IDLE.
REQ-017 GOT_ARG: terminator -> emit with the latched arg; other byte -> err_code 2, return to IDLE.
REQ-018 A '!' received in any non-IDLE state SHALL abort the current frame silently (no err) and go to GOT_START.
REQ-019 Latency: cmd_valid/err SHALL be high in the cycle immediately after the cycle in which the triggering strobe is detected; all outputs are registered.
REQ-020 cmd_valid and err SHALL never be high in the same cycle; the FSM returns to IDLE in the same cycle it emits.
REQ-021 Timeout counter, 25 bits: cleared on every strobe and held at 0 in IDLE, incremented otherwise; on reaching TIMEOUT_CYCLES-1 in a non-IDLE state -> err_code 3, return to IDLE.
REQ-022 A strobe in the same cycle as the timeout SHALL take priority; the byte is processed and no timeout err is raised.
REQ-023 cmd_code, cmd_arg and err_code SHALL hold their last values between pulses.

Reset
REQ-024 While rst_n=0: FSM IDLE, timeout counter 0, previous-byte register 0, cmd_valid 0, err 0, busy 0, cmd_code 0, cmd_arg 0, err_code 0.
REQ-025 Reset asserted mid-frame SHALL discard the frame with no pulse; after release, a byte already held nonzero on rx_data SHALL NOT strobe until rx_data returns to 0.

Structure
REQ-026 Shared package tama_pkg SHALL hold: the command-code constants, the error-code constants, the ASCII constants ('!', CR, LF, '0', the letters) and the FSM state encoding.
REQ-027 Sub-module byte_strobe (previous-value register plus edge detect, producing strobe and the byte) SHALL be instantiated once; all else stays in cmd_parser.

Verification
REQ-028 Drive "!F3\r", each byte held 50 cycles with 5 zero cycles between bytes -> single cmd_valid, cmd_code=0, cmd_arg=3, one cycle after the CR strobe; err never high.
REQ-029 Drive "!T\n" -> cmd_valid, cmd_code=5, cmd_arg=1.
REQ-030 Drive "!X\r" -> err, err_code=1 after 'X'; the following CR is ignored; busy=0 afterwards.
REQ-031 Drive "!P7x" -> err_code=2 on 'x'; then "!!C\r" -> exactly one cmd_valid, cmd_code=2, cmd_arg=1, and no err.
REQ-032 With TIMEOUT_CYCLES=100: drive "!S", then idle 100 cycles -> err_code=3 exactly 100 cycles after the 'S' strobe; repeat with a byte arriving on the timeout cycle -> no err.
REQ-033 Assert rst_n=0 after "!W" while rx_data is held at 'W', then release -> no pulses, busy=0, no strobe until rx_data returns to 0.
